icache_ctrl: RTL and testbench

- Fetch sequencer sitting between the IF stage, the direct-mapped icache and the shared byte-wide memory port.
- On a request it looks up the icache. A hit returns the word next cycle.
- A miss requests the memory port from the external memory arbiter, then reads 4 bytes little-endian and assembles the word.
- It then writes the word into the icache and returns it to IF. A branch redirect (flush) aborts an in-progress fetch cleanly.

---
 rtl/icache_ctrl_pkg.sv | 25 ++
 rtl/icache_ctrl.sv | 151 +++++++++++++++
 tb/tb_icache_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_ctrl_pkg.sv
// Shared types for the IF-stage fetch sequencer: FSM encoding, debug view
// and the little-endian byte-to-word assembly helper.
package icache_ctrl_pkg;

    typedef enum logic [1:0] {
        IC_IDLE     = 2'd0,
        IC_WAIT_GNT = 2'd1,
        IC_FETCH    = 2'd2,
        IC_WRITE    = 2'd3
    } ic_state_t;

    typedef struct packed {
        ic_state_t  state;
        logic [2:0] cnt;
    } ic_dbg_t;

    localparam logic [2:0] CNT_LAST_ADDR = 3'd3;
    localparam logic [2:0] CNT_LAST      = 3'd4;

    function automatic logic [31:0] assemble(input logic [7:0] b3, input logic [7:0] b2,
                                             input logic [7:0] b1, input logic [7:0] b0);
        return {b3, b2, b1, b0};
    endfunction

endpackage

// File: rtl/icache_ctrl.sv
// Fetch sequencer between IF, the direct-mapped icache and the byte-wide memory
// port: hits ack next cycle, misses fill a word over four byte reads.
module icache_ctrl
    import icache_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_pc_i,
    output logic              if_ack_o,
    output logic [INST_W-1:0] if_inst_o,
    input  logic              flush_i,
    output logic [ADDR_W-1:0] ic_rpc_o,
    input  logic              ic_hit_i,
    input  logic [INST_W-1:0] ic_inst_i,
    output logic              ic_we_o,
    output logic [ADDR_W-1:0] ic_wpc_o,
    output logic [INST_W-1:0] ic_winst_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [ADDR_W-1:0] mem_a_o,
    input  logic [7:0]        mem_din_i,
    output ic_dbg_t           dbg_o
);

    // Handshake: IF holds if_req_i/if_pc_i until the one-cycle if_ack_o pulse;
    // a request seen while if_ack_o is high belongs to the finished fetch and is ignored.
    ic_state_t         state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [7:0]        byte_q [4];
    logic [7:0]        byte_d [4];
    logic              if_ack_q, if_ack_d;
    logic [INST_W-1:0] if_inst_q, if_inst_d;
    logic              ic_we_q, ic_we_d;
    logic [ADDR_W-1:0] ic_wpc_q, ic_wpc_d;
    logic [INST_W-1:0] ic_winst_q, ic_winst_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [INST_W-1:0] word_full;

    // The last byte arrives in the same cycle the word is committed.
    assign word_full = INST_W'(assemble(mem_din_i, byte_q[2], byte_q[1], byte_q[0]));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        byte_d     = byte_q;
        if_ack_d   = 1'b0;
        if_inst_d  = if_inst_q;
        ic_we_d    = 1'b0;
        ic_wpc_d   = ic_wpc_q;
        ic_winst_d = ic_winst_q;
        mem_req_d  = mem_req_q;
        mem_a_d    = mem_a_q;

        if (flush_i && state_q != IC_WRITE) begin
            state_d   = IC_IDLE;
            cnt_d     = 3'd0;
            mem_req_d = 1'b0;
            for (int i = 0; i < 4; i++) byte_d[i] = 8'h00;
        end else begin
            case (state_q)
                IC_IDLE: begin
                    if (if_req_i && !if_ack_q) begin
                        if (ic_hit_i) begin
                            if_ack_d  = 1'b1;
                            if_inst_d = ic_inst_i;
                        end else begin
                            base_d    = {if_pc_i[ADDR_W-1:2], 2'b00};
                            mem_req_d = 1'b1;
                            state_d   = IC_WAIT_GNT;
                        end
                    end
                end
                IC_WAIT_GNT: begin
                    if (mem_gnt_i) begin
                        state_d = IC_FETCH;
                        cnt_d   = 3'd0;
                        mem_a_d = base_q;
                    end
                end
                IC_FETCH: begin
                    if (cnt_q != 3'd0) byte_d[2'(cnt_q - 3'd1)] = mem_din_i;
                    if (cnt_q < CNT_LAST_ADDR) mem_a_d = base_q + ADDR_W'(cnt_q + 3'd1);
                    if (cnt_q == CNT_LAST) begin
                        state_d    = IC_WRITE;
                        cnt_d      = 3'd0;
                        mem_req_d  = 1'b0;
                        ic_we_d    = 1'b1;
                        ic_wpc_d   = base_q;
                        ic_winst_d = word_full;
                        if_ack_d   = 1'b1;
                        if_inst_d  = word_full;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                IC_WRITE: begin
                    state_d = IC_IDLE;
                end
                default: state_d = IC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IC_IDLE;
            cnt_q      <= 3'd0;
            base_q     <= '0;
            for (int i = 0; i < 4; i++) byte_q[i] <= 8'h00;
            if_ack_q   <= 1'b0;
            if_inst_q  <= '0;
            ic_we_q    <= 1'b0;
            ic_wpc_q   <= '0;
            ic_winst_q <= '0;
            mem_req_q  <= 1'b0;
            mem_a_q    <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            for (int i = 0; i < 4; i++) byte_q[i] <= byte_d[i];
            if_ack_q   <= if_ack_d;
            if_inst_q  <= if_inst_d;
            ic_we_q    <= ic_we_d;
            ic_wpc_q   <= ic_wpc_d;
            ic_winst_q <= ic_winst_d;
            mem_req_q  <= mem_req_d;
            mem_a_q    <= mem_a_d;
        end
    end

    // A redirect arriving during WRITE still fills the icache but must not hand IF a stale word.
    assign if_ack_o   = if_ack_q & ~(flush_i & (state_q == IC_WRITE));
    assign if_inst_o  = if_inst_q;
    assign ic_rpc_o   = if_pc_i;
    assign ic_we_o    = ic_we_q;
    assign ic_wpc_o   = ic_wpc_q;
    assign ic_winst_o = ic_winst_q;
    assign mem_req_o  = mem_req_q;
    assign mem_a_o    = mem_a_q;
    assign dbg_o      = {state_q, cnt_q};

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: directed fetches against a small icache, byte memory
// and arbiter model, with a queue-based scoreboard on acks and icache writes.
module tb_icache_ctrl;
    import icache_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        if_req_i;
    logic [31:0] if_pc_i;
    logic        if_ack_o;
    logic [31:0] if_inst_o;
    logic        flush_i;
    logic [31:0] ic_rpc_o;
    logic        ic_hit_i;
    logic [31:0] ic_inst_i;
    logic        ic_we_o;
    logic [31:0] ic_wpc_o;
    logic [31:0] ic_winst_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [31:0] mem_a_o;
    logic [7:0]  mem_din_i;
    ic_dbg_t     dbg_o;

    icache_ctrl #(.ADDR_W(32), .INST_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .if_req_i(if_req_i), .if_pc_i(if_pc_i), .if_ack_o(if_ack_o), .if_inst_o(if_inst_o),
        .flush_i(flush_i), .ic_rpc_o(ic_rpc_o), .ic_hit_i(ic_hit_i), .ic_inst_i(ic_inst_i),
        .ic_we_o(ic_we_o), .ic_wpc_o(ic_wpc_o), .ic_winst_o(ic_winst_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_a_o(mem_a_o),
        .mem_din_i(mem_din_i), .dbg_o(dbg_o)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000 ns");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];
    int          exp_c_q[$];
    logic [31:0] exp_wpc_q[$];
    logic [31:0] exp_wd_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- icache model (16-entry direct-mapped) ----------------
    logic        ic_clr, pre_we;
    logic [31:0] pre_pc, pre_data;
    logic [15:0] ic_v;
    logic [31:0] ic_tag  [16];
    logic [31:0] ic_data [16];

    always_comb begin
        ic_hit_i  = ic_v[if_pc_i[5:2]] && (ic_tag[if_pc_i[5:2]] == if_pc_i);
        ic_inst_i = ic_data[if_pc_i[5:2]];
    end

    always @(posedge clk) begin
        if (ic_clr) begin
            ic_v <= '0;
        end else if (pre_we) begin
            ic_v[pre_pc[5:2]]    <= 1'b1;
            ic_tag[pre_pc[5:2]]  <= pre_pc;
            ic_data[pre_pc[5:2]] <= pre_data;
        end else if (rdy && ic_we_o) begin
            ic_v[ic_wpc_o[5:2]]    <= 1'b1;
            ic_tag[ic_wpc_o[5:2]]  <= ic_wpc_o;
            ic_data[ic_wpc_o[5:2]] <= ic_winst_o;
        end
    end

    // ---------------- byte memory and arbiter models ----------------
    logic [7:0] mem [4096];
    always @(posedge clk) if (rdy) mem_din_i <= mem[mem_a_o[11:0]];

    int         gnt_delay = 0;
    logic [3:0] wait_cnt;
    logic       gnt_prev;
    assign mem_gnt_i = mem_req_o && (int'(wait_cnt) >= gnt_delay);

    always @(posedge clk) begin
        if (!mem_req_o) wait_cnt <= 4'd0;
        else if (rdy && wait_cnt != 4'hF) wait_cnt <= wait_cnt + 4'd1;
    end

    always @(negedge clk) begin
        if (rst_n) assert (!(mem_req_o && gnt_prev && !mem_gnt_i))
            else $error("grant dropped while mem_req_o high");
        gnt_prev <= mem_gnt_i;
    end

    // ---------------- monitor ----------------
    logic [31:0] m_inst, m_pc;
    int          m_c;
    always @(negedge clk) begin
        if (rst_n && if_ack_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'(if_ack_o), 32'd0);
            end else begin
                m_inst = exp_q.pop_front();
                m_c    = exp_c_q.pop_front();
                check("ack_inst", if_inst_o, m_inst);
                check("ack_cycle", 32'(cyc), 32'(m_c));
            end
        end
        if (rst_n && ic_we_o) begin
            if (exp_wpc_q.size() == 0) begin
                check("unexpected_ic_we", 32'(ic_we_o), 32'd0);
            end else begin
                m_pc   = exp_wpc_q.pop_front();
                m_inst = exp_wd_q.pop_front();
                check("ic_wpc", ic_wpc_o, m_pc);
                check("ic_winst", ic_winst_o, m_inst);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[12'(a + 32'(i))] = w[8*i +: 8];
    endtask

    task automatic preload(input logic [31:0] pc, input logic [31:0] d);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_pc = pc; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] inst, input int lat,
                            input bit miss, input int gdel, input bit chk_addr);
        int c0;
        bit acked, req_ok;
        @(posedge clk); #1;
        gnt_delay = gdel;
        if_req_i  = 1'b1;
        if_pc_i   = pc;
        c0        = cyc;
        exp_q.push_back(inst);
        exp_c_q.push_back(c0 + lat);
        if (miss) begin
            exp_wpc_q.push_back(pc);
            exp_wd_q.push_back(inst);
        end
        acked  = 1'b0;
        req_ok = 1'b1;
        for (int k = 0; k < 40 && !acked; k++) begin
            @(negedge clk);
            if (k == 0) check("ic_rpc", ic_rpc_o, pc);
            if (chk_addr && k >= 2 + gdel && k <= 5 + gdel)
                check("mem_a", mem_a_o, pc + 32'(k - 2 - gdel));
            if (miss && k >= 1 && k < lat && !mem_req_o) req_ok = 1'b0;
            if (k == lat && mem_req_o) req_ok = 1'b0;
            if (!miss && mem_req_o) req_ok = 1'b0;
            if (if_ack_o) acked = 1'b1;
        end
        check("ack_seen", 32'(acked), 32'd1);
        check(miss ? "mem_req_window" : "mem_req_quiet", 32'(req_ok), 32'd1);
        @(posedge clk); #1;
        if_req_i = 1'b0;
    endtask

    task automatic start_req(input logic [31:0] pc);
        @(posedge clk); #1;
        gnt_delay = 0;
        if_req_i  = 1'b1;
        if_pc_i   = pc;
    endtask

    task automatic next_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; rdy = 1'b1; if_req_i = 1'b0; if_pc_i = '0; flush_i = 1'b0;
        ic_clr = 1'b1; pre_we = 1'b0; pre_pc = '0; pre_data = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5A;
        set_word(32'h204, 32'h0010_0513);
        set_word(32'h308, 32'h0010_0093);
        set_word(32'h40C, 32'h4433_2211);
        set_word(32'h510, 32'h0000_40B7);
        set_word(32'h614, 32'h00B5_2023);
        set_word(32'h718, 32'h0100_006F);
        set_word(32'h81C, 32'h00A5_8633);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(if_ack_o), 32'd0);
        check("rst_inst", if_inst_o, 32'd0);
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_mem_a", mem_a_o, 32'd0);
        check("rst_ic_we", 32'(ic_we_o), 32'd0);
        check("rst_state", 32'(dbg_o.state), 32'(IC_IDLE));
        @(posedge clk); #1;
        rst_n = 1'b1; ic_clr = 1'b0;

        // hit
        preload(32'h100, 32'hDEAD_BEEF);
        do_fetch(32'h100, 32'hDEAD_BEEF, 1, 1'b0, 0, 1'b0);

        // miss with immediate grant, then the same pc hits
        do_fetch(32'h204, 32'h0010_0513, 7, 1'b1, 0, 1'b1);
        do_fetch(32'h204, 32'h0010_0513, 1, 1'b0, 0, 1'b0);

        // grant held off for three cycles
        do_fetch(32'h308, 32'h0010_0093, 10, 1'b1, 3, 1'b1);

        // flush in FETCH at cnt=2, then a fresh miss
        start_req(32'h40C);
        next_cycles(4);
        flush_i = 1'b1; if_req_i = 1'b0;
        @(negedge clk);
        check("flush_cnt_before", 32'(dbg_o.cnt), 32'd2);
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        check("flush_state_idle", 32'(dbg_o.state), 32'(IC_IDLE));
        check("flush_mem_req", 32'(mem_req_o), 32'd0);
        next_cycles(6);
        do_fetch(32'h510, 32'h0000_40B7, 7, 1'b1, 0, 1'b1);

        // flush during WRITE: icache still written, no ack
        exp_wpc_q.push_back(32'h614);
        exp_wd_q.push_back(32'h00B5_2023);
        start_req(32'h614);
        next_cycles(7);
        flush_i = 1'b1; if_req_i = 1'b0;
        @(negedge clk);
        check("wflush_ic_we", 32'(ic_we_o), 32'd1);
        check("wflush_ack", 32'(if_ack_o), 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        do_fetch(32'h614, 32'h00B5_2023, 1, 1'b0, 0, 1'b0);

        // asynchronous reset at cnt=3
        start_req(32'h718);
        next_cycles(5);
        check("prerst_mem_a", mem_a_o, 32'h71B);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mem_req", 32'(mem_req_o), 32'd0);
        check("arst_mem_a", mem_a_o, 32'd0);
        check("arst_inst", if_inst_o, 32'd0);
        check("arst_state", 32'(dbg_o.state), 32'(IC_IDLE));
        check("arst_cnt", 32'(dbg_o.cnt), 32'd0);
        if_req_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        next_cycles(3);

        // rdy low for two cycles while cnt=1
        fork
            do_fetch(32'h81C, 32'h00A5_8633, 9, 1'b1, 0, 1'b0);
            begin
                @(posedge clk); #1;
                next_cycles(3);
                rdy = 1'b0;
                @(posedge clk); #1;
                @(negedge clk);
                check("stall_mem_a", mem_a_o, 32'h81D);
                check("stall_cnt", 32'(dbg_o.cnt), 32'd1);
                @(posedge clk); #1;
                rdy = 1'b1;
            end
        join

        next_cycles(5);
        check("ack_queue_drained", 32'(exp_q.size()), 32'd0);
        check("write_queue_drained", 32'(exp_wpc_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
